game_timer: RTL

GAME_TIMER -- requirements
Module: game_timer

---
 rtl/game_timer_pkg.sv | 15 +
 rtl/game_timer_tick_gen.sv | 33 +++
 rtl/game_timer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game countdown timer.
// The state encoding and the extra-bit rule used to detect saturating-add overflow live here.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // An unsigned add of two COUNT_W values needs this many extra bits to expose overflow.
  localparam int SAT_GUARD_BITS = 1;

endpackage

// File: rtl/game_timer_tick_gen.sv
// Prescaler that divides the system clock down to the countdown rate.
// It advances only while enabled, holds otherwise, and pulses tick on its terminal count.
module tick_gen #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] prescale;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      prescale <= '0;
    end else if (clear) begin
      prescale <= '0;
    end else if (enable) begin
      prescale <= (prescale == TERM) ? '0 : prescale + 1'b1;
    end
  end

  assign tick = enable && (prescale == TERM);

endmodule

// File: rtl/game_timer.sv
// Countdown game timer: start/pause/resume, load, saturating bonus time,
// low-time warning and a one-cycle expiry pulse on reaching zero.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int TICK_HZ    = 1,
  parameter int COUNT_W    = 16,
  parameter int START_TIME = 20,
  parameter int WARN_TIME  = 5
) (
  input  logic               clock_100Mhz,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               add_time,
  input  logic [COUNT_W-1:0] bonus,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               warning,
  output logic               expired,
  output logic               time_up
);

  localparam int SUM_W = COUNT_W + SAT_GUARD_BITS;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] START_C   = COUNT_W'(START_TIME);
  localparam logic [COUNT_W-1:0] WARN_C    = COUNT_W'(WARN_TIME);
  localparam logic [COUNT_W-1:0] ONE       = COUNT_W'(1);

  state_t             state, state_next;
  logic [COUNT_W-1:0] count_next;
  logic [COUNT_W-1:0] eff;
  logic               expire_next;
  logic               clear;
  logic               tick;

  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s > SUM_W'(COUNT_MAX)) ? COUNT_MAX : s[COUNT_W-1:0];
  endfunction

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clock_100Mhz(clock_100Mhz),
    .reset       (reset),
    .enable      (running),
    .clear       (clear),
    .tick        (tick)
  );

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= START_C;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      expired <= expire_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next  = state;
    count_next  = count;
    expire_next = 1'b0;
    clear       = 1'b0;
    eff         = count;
    if (load) begin
      state_next = IDLE;
      count_next = load_value;
      clear      = 1'b1;
    end else begin
      if (add_time && (state == RUN || state == PAUSE)) begin
        eff = sat_add(count, bonus);
      end
      count_next = eff;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_next = RUN;
            clear      = 1'b1;
            if (count == '0) count_next = START_C;
          end
        end
        PAUSE: begin
          if (start) state_next = RUN;
        end
        RUN: begin
          // Pause outranks the tick; start is meaningless while already running.
          if (pause) begin
            state_next = PAUSE;
          end else if (tick) begin
            if (eff > ONE) begin
              count_next = eff - ONE;
            end else begin
              count_next  = '0;
              state_next  = DONE;
              expire_next = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state == RUN);
    time_up = (state == DONE);
    warning = (state == RUN) && (count != '0) && (count <= WARN_C);
  end

endmodule
